// File: rtl/apb_mem_slave.sv
// Parametrised APB memory slave with byte strobes, wait states and PSLVERR on out-of-range access.
// Optional write-protect window enabled by defining APB_MEM_WPROT_EN (adds wprot_en port and WPROT_WORDS).
module apb_mem_slave #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
`ifdef APB_MEM_WPROT_EN
  ,
  parameter int WPROT_WORDS = 16
`endif
) (
  input  logic            clk,
  input  logic            rst,
`ifdef APB_MEM_WPROT_EN
  input  logic            wprot_en,
`endif
  input  logic            psel,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [AW-1:0]   paddr,
  input  logic [DW-1:0]   pwdata,
  input  logic [DW/8-1:0] pstrb,
  output logic            pready,
  output logic [DW-1:0]   prdata,
  output logic            pslverr
);

  localparam int NB  = DW / 8;
  localparam int OFF = $clog2(NB);
  localparam int XW  = AW - OFF;
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XW:0] DEPTH_X = (XW+1)'(DEPTH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]    state;
  logic [3:0]    cnt;
  logic [DW-1:0] mem [DEPTH];

  logic [XW-1:0] idx;
  logic [IW-1:0] widx;
  logic          range_err;
  logic          prot_hit;
  logic          err_now;
  logic          finish;
  logic          commit;

  assign idx       = paddr[AW-1:OFF];
  assign widx      = idx[IW-1:0];
  // Full-width compare so out-of-range addresses never alias onto low words.
  assign range_err = ({1'b0, idx} >= DEPTH_X);

`ifdef APB_MEM_WPROT_EN
  localparam logic [XW:0] WPROT_X = (XW+1)'(WPROT_WORDS);
  assign prot_hit = wprot_en && ({1'b0, idx} < WPROT_X);
`else
  assign prot_hit = 1'b0;
`endif

  // Protection only blocks writes; reads of the window behave normally.
  assign err_now = range_err | (pwrite & prot_hit);

  generate
    if (OFF > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^paddr[OFF-1:0];
    end
  endgenerate

  // Edge on which pready rises: straight out of setup when there are no
  // wait states, otherwise when the wait counter expires.
  always_comb begin
    finish = 1'b0;
    commit = 1'b0;
    if (state == IDLE) begin
      finish = psel && !penable && (WAIT_CYCLES == 0);
    end else if (psel) begin
      finish = !pready && (cnt == 4'd1);
      commit = pready && penable;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (finish) begin
        pready  <= 1'b1;
        pslverr <= err_now;
        if (!pwrite) prdata <= range_err ? '0 : mem[widx];
      end
      case (state)
        IDLE: begin
          if (psel && !penable) begin
            state <= ACCESS;
            cnt   <= 4'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (!psel) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
          end else if (!pready) begin
            cnt <= cnt - 4'd1;
          end else if (commit) begin
            if (pwrite && !err_now) begin
              for (int b = 0; b < NB; b++)
                if (pstrb[b]) mem[widx][b*8 +: 8] <= pwdata[b*8 +: 8];
            end
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
